sevenseg_scan_ctrl: RTL and testbench

Scan scheduler for the 4-digit multiplexed seven-segment display in the vending machine FSM design. It divides the system clock into per-digit time slots and rotates the active digit select. It drives the active-low anode lines and presents the nibble and decimal point for the current digit. New display frames are accepted through a load/ready handshake and double-buffered, so a value change only takes effect at a frame boundary (no tearing).

---
 rtl/display_pkg.sv | 33 +++
 rtl/sevenseg_scan_ctrl_if.sv | 45 ++++
 rtl/scan_tick_gen.sv | 41 ++++
 rtl/sevenseg_scan_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the multiplexed seven-segment display path.
//   scan_state_t : per-slot scan phase (BLANK dead time, DRIVE lit)
//   AN_OFF       : anode pattern with every digit dark (anodes are active low)
//   AN_DIGn      : one-cold anode pattern selecting digit n
//   an_decode()  : digit index -> one-cold anode pattern
// -----------------------------------------------------------------------------
package display_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

   localparam logic [3:0] AN_OFF  = 4'b1111;
   localparam logic [3:0] AN_DIG0 = 4'b1110;
   localparam logic [3:0] AN_DIG1 = 4'b1101;
   localparam logic [3:0] AN_DIG2 = 4'b1011;
   localparam logic [3:0] AN_DIG3 = 4'b0111;

   function automatic logic [3:0] an_decode(input logic [1:0] idx);
      logic [3:0] an;
      case (idx)
         2'd0:    an = AN_DIG0;
         2'd1:    an = AN_DIG1;
         2'd2:    an = AN_DIG2;
         default: an = AN_DIG3;
      endcase
      return an;
   endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_ctrl_if
// Frame-load channel of the display scan controller.
//   load    : writer requests a new frame
//   din     : four nibbles, digit0 = din[3:0] .. digit3 = din[15:12]
//   dp_in   : decimal points, bit n belongs to digit n
//   mask_in : digit enables, 1 = digit lit
//   ready   : shadow buffer free
//   applied : one-cycle pulse when the shadow frame becomes the active frame
//
// Handshake: a frame transfers on every rising clk edge where load=1 and
// ready=1. A load seen while ready=0 is dropped without side effects, and the
// writer need not hold its data after the transfer edge. ready stays low from
// the cycle after a transfer until the cycle after the matching applied pulse.
//
// master = frame writer, slave = scan controller.
// -----------------------------------------------------------------------------
interface sevenseg_scan_ctrl_if;

   logic        load;
   logic [15:0] din;
   logic [3:0]  dp_in;
   logic [3:0]  mask_in;
   logic        ready;
   logic        applied;

   modport master (
      output load,
      output din,
      output dp_in,
      output mask_in,
      input  ready,
      input  applied
   );

   modport slave (
      input  load,
      input  din,
      input  dp_in,
      input  mask_in,
      output ready,
      output applied
   );

endinterface

// File: rtl/scan_tick_gen.sv
// -----------------------------------------------------------------------------
// scan_tick_gen
// Slot timer for the display scan: a counter running 0..REFRESH_DIV-1.
//   clk         : system clock, rising edge
//   reset       : asynchronous, active high; counter returns to 0
//   slot_end_o  : current count is the last cycle of the slot
//   in_blank_o  : the count entered on the next edge is below BLANK_CYC
//
// in_blank_o looks one count ahead so that a state register loaded from it
// holds BLANK exactly while the counter itself is below BLANK_CYC.
// -----------------------------------------------------------------------------
module scan_tick_gen #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_CYC   = 16
) (
   input  logic clk,
   input  logic reset,
   output logic slot_end_o,
   output logic in_blank_o
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign slot_end_o = (cnt_q == CNT_LAST);
   assign cnt_d      = slot_end_o ? '0 : (cnt_q + CW'(1));
   assign in_blank_o = (cnt_d < BLANK_LIM);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_ctrl
// Scan scheduler for a 4-digit multiplexed seven-segment display. Rotates the
// active digit every REFRESH_DIV cycles, drives active-low anodes and presents
// the nibble / decimal point of the current digit. New frames arrive through a
// load/ready handshake into a shadow buffer and are copied to the active frame
// only at the 3->0 digit wrap, so a displayed value never tears.
//
// Ports:
//   clk, reset  : clock (rising edge), asynchronous active-high reset
//   bus         : frame-load channel (slave side), see sevenseg_scan_ctrl_if
//   frame_start : one-cycle pulse in the cycle S becomes 0 after 3
//   S           : current digit index
//   AN          : anode drive, active low, one-hot-zero, registered
//   digit, dp   : nibble and decimal point of digit S from the active frame
//   state       : current scan phase (BLANK / DRIVE), for observation
//
// Build option: define SCAN_BLANK_EN to hold AN dark for the first BLANK_CYC
// cycles of each slot (anti-ghosting dead time). Without it the scan phase
// stays DRIVE and AN is valid on every cycle.
// -----------------------------------------------------------------------------
module sevenseg_scan_ctrl
   import display_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_CYC   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   sevenseg_scan_ctrl_if.slave  bus,
   output logic                 frame_start,
   output logic [1:0]           S,
   output logic [3:0]           AN,
   output logic [3:0]           digit,
   output logic                 dp,
   output scan_state_t          state
);

`ifdef SCAN_BLANK_EN
   localparam scan_state_t ST_RESET = BLANK;
`else
   localparam scan_state_t ST_RESET = DRIVE;
`endif

   logic slot_end;
   logic in_blank;

   scan_tick_gen #(
      .REFRESH_DIV (REFRESH_DIV),
      .BLANK_CYC   (BLANK_CYC)
   ) u_tick (
      .clk        (clk),
      .reset      (reset),
      .slot_end_o (slot_end),
      .in_blank_o (in_blank)
   );

   logic [1:0]  s_q, s_d;
   scan_state_t state_q, state_d;
   logic [15:0] act_dig_q, act_dig_d;
   logic [3:0]  act_dp_q, act_dp_d;
   logic [3:0]  act_mask_q, act_mask_d;
   logic [15:0] sh_dig_q;
   logic [3:0]  sh_dp_q;
   logic [3:0]  sh_mask_q;
   logic        pending_q, pending_d;
   logic        applied_q;
   logic        frame_start_q;
   logic [3:0]  an_q, an_d;
   logic [3:0]  digit_q, digit_d;
   logic        dp_q, dp_d;
   logic        accept;
   logic        boundary;
   logic        apply_now;

   assign accept    = bus.load & ~pending_q;
   assign boundary  = slot_end & (s_q == 2'd3);
   // pending_q is still 0 in a boundary cycle that accepts a load, so that
   // frame waits for the following boundary.
   assign apply_now = boundary & pending_q;

   always_comb begin
      s_d        = slot_end ? (s_q + 2'd1) : s_q;

      act_dig_d  = act_dig_q;
      act_dp_d   = act_dp_q;
      act_mask_d = act_mask_q;
      if (apply_now) begin
         act_dig_d  = sh_dig_q;
         act_dp_d   = sh_dp_q;
         act_mask_d = sh_mask_q;
      end

      // pending is released one cycle after the apply so that ready rises
      // in the cycle following the applied pulse.
      pending_d = pending_q;
      if (applied_q) begin
         pending_d = 1'b0;
      end
      if (accept) begin
         pending_d = 1'b1;
      end

`ifdef SCAN_BLANK_EN
      state_d = in_blank ? BLANK : DRIVE;
`else
      state_d = DRIVE;
`endif

      // Outputs are computed from next-state values so S, AN, digit and dp
      // all change on the same edge.
      an_d    = (state_d == BLANK) ? AN_OFF : (an_decode(s_d) | ~act_mask_d);
      digit_d = act_dig_d[{s_d, 2'b00} +: 4];
      dp_d    = act_dp_d[s_d];
   end

`ifndef SCAN_BLANK_EN
   logic unused_in_blank;
   assign unused_in_blank = in_blank;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_q           <= 2'd0;
         state_q       <= ST_RESET;
         act_dig_q     <= 16'h0000;
         act_dp_q      <= 4'b0000;
         act_mask_q    <= 4'b0000;
         pending_q     <= 1'b0;
         applied_q     <= 1'b0;
         frame_start_q <= 1'b0;
         an_q          <= AN_OFF;
         digit_q       <= 4'h0;
         dp_q          <= 1'b0;
      end else begin
         s_q           <= s_d;
         state_q       <= state_d;
         act_dig_q     <= act_dig_d;
         act_dp_q      <= act_dp_d;
         act_mask_q    <= act_mask_d;
         pending_q     <= pending_d;
         applied_q     <= apply_now;
         frame_start_q <= boundary;
         an_q          <= an_d;
         digit_q       <= digit_d;
         dp_q          <= dp_d;
      end
   end

   // Shadow buffer: only written on an accepted load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_dig_q  <= 16'h0000;
         sh_dp_q   <= 4'b0000;
         sh_mask_q <= 4'b0000;
      end else if (accept) begin
         sh_dig_q  <= bus.din;
         sh_dp_q   <= bus.dp_in;
         sh_mask_q <= bus.mask_in;
      end
   end

   assign bus.ready   = ~pending_q;
   assign bus.applied = applied_q;
   assign frame_start = frame_start_q;
   assign S           = s_q;
   assign AN          = an_q;
   assign digit       = digit_q;
   assign dp          = dp_q;
   assign state       = state_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan_ctrl
// Self-checking bench for sevenseg_scan_ctrl with REFRESH_DIV=4, BLANK_CYC=1.
// Accepted frames are pushed to exp_q when driven and popped when the frame
// boundary applies them; the popped frame is the reference for digit/dp/AN.
// Dead-time expectations follow SCAN_BLANK_EN, so the same file serves both
// builds.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan_ctrl;
   import display_pkg::*;

   localparam int RD = 4;
   localparam int BC = 1;
   localparam int FR = 4 * RD;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_start;
   logic [1:0]  S;
   logic [3:0]  AN;
   logic [3:0]  digit;
   logic        dp;
   scan_state_t state;

   sevenseg_scan_ctrl_if bus();

   sevenseg_scan_ctrl #(
      .REFRESH_DIV (RD),
      .BLANK_CYC   (BC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .frame_start (frame_start),
      .S           (S),
      .AN          (AN),
      .digit       (digit),
      .dp          (dp),
      .state       (state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- model / scoreboard ----------------
   int          checks = 0;
   int          errors = 0;
   int          k;                // rising edges since reset release
   bit          m_pending;
   bit          m_applied;
   bit          m_frame_start;
   logic [23:0] m_active;         // {mask, dp, din}
   logic [23:0] exp_q[$];

   function automatic logic [3:0] exp_an(input int kk, input logic [3:0] mask);
      logic [3:0] sel;
      sel = 4'b0001 << ((kk / RD) % 4);
`ifdef SCAN_BLANK_EN
      if ((kk % RD) < BC) return 4'b1111;
`endif
      return ~(sel & mask);
   endfunction

   function automatic logic [3:0] exp_digit(input int kk);
      return m_active[((kk / RD) % 4) * 4 +: 4];
   endfunction

   function automatic logic exp_dp(input int kk);
      return m_active[16 + ((kk / RD) % 4)];
   endfunction

   task automatic model_init();
      k             = 0;
      m_pending     = 1'b0;
      m_applied     = 1'b0;
      m_frame_start = 1'b0;
      m_active      = 24'h0;
      exp_q.delete();
   endtask

   // Advance one clock and update the reference model from the inputs that
   // were present at that edge.
   task automatic step();
      bit          acc;
      bit          bnd;
      bit          clr;
      logic [23:0] frame;
      acc   = (bus.load === 1'b1) && !m_pending;
      bnd   = ((k % FR) == FR - 1);
      clr   = m_applied;
      frame = {bus.mask_in, bus.dp_in, bus.din};
      @(posedge clk);
      #1;
      k             = k + 1;
      m_frame_start = bnd;
      m_applied     = bnd && m_pending;
      if (m_applied && exp_q.size() > 0) m_active = exp_q.pop_front();
      if (clr) m_pending = 1'b0;
      if (acc) begin
         m_pending = 1'b1;
         exp_q.push_back(frame);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      bus.load = 1'b0;
      reset    = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_init();
   endtask

   task automatic wait_phase(input int ph);
      for (int i = 0; i < FR; i++) begin
         if ((k % FR) == ph) break;
         step();
      end
   endtask

   task automatic drive_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] m);
      bus.din     = d;
      bus.dp_in   = p;
      bus.mask_in = m;
      bus.load    = 1'b1;
      step();
      bus.load    = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      checks++; if (AN !== 4'b1111) begin errors++; $display("FAIL reset_an got=%b exp=1111", AN); end
      checks++; if (S !== 2'd0) begin errors++; $display("FAIL reset_s got=%0d exp=0", S); end
      checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
      checks++; if (bus.applied !== 1'b0) begin errors++; $display("FAIL reset_applied got=%b exp=0", bus.applied); end
      checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got=%b exp=0", frame_start); end
      checks++; if (digit !== 4'h0 || dp !== 1'b0) begin errors++; $display("FAIL reset_digit got=%h/%b exp=0/0", digit, dp); end
`ifdef SCAN_BLANK_EN
      checks++; if (state !== BLANK) begin errors++; $display("FAIL reset_state got=%0d exp=BLANK", state); end
`else
      checks++; if (state !== DRIVE) begin errors++; $display("FAIL reset_state got=%0d exp=DRIVE", state); end
`endif
      for (int i = 0; i < 40; i++) begin
         step();
         checks++; if (AN !== 4'b1111) begin errors++; $display("FAIL idle_an k=%0d got=%b exp=1111", k, AN); end
         checks++; if (S !== 2'((k / RD) % 4)) begin errors++; $display("FAIL idle_s k=%0d got=%0d exp=%0d", k, S, (k / RD) % 4); end
         checks++; if (frame_start !== m_frame_start) begin errors++; $display("FAIL idle_frame_start k=%0d got=%b exp=%b", k, frame_start, m_frame_start); end
      end
   endtask

   task automatic test_load_apply();
      int seen;
      seen = 0;
      wait_phase(5);
      drive_load(16'h4321, 4'b0101, 4'b1111);
      checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL load_ready_drop got=%b exp=0", bus.ready); end
      for (int i = 0; i < 32; i++) begin
         step();
         checks++; if (bus.applied !== m_applied) begin errors++; $display("FAIL load_applied k=%0d got=%b exp=%b", k, bus.applied, m_applied); end
         checks++; if (bus.ready !== !m_pending) begin errors++; $display("FAIL load_ready k=%0d got=%b exp=%b", k, bus.ready, !m_pending); end
         checks++; if (AN !== exp_an(k, m_active[23:20])) begin errors++; $display("FAIL load_an k=%0d got=%b exp=%b", k, AN, exp_an(k, m_active[23:20])); end
         checks++; if (digit !== exp_digit(k)) begin errors++; $display("FAIL load_digit k=%0d got=%h exp=%h", k, digit, exp_digit(k)); end
         checks++; if (dp !== exp_dp(k)) begin errors++; $display("FAIL load_dp k=%0d got=%b exp=%b", k, dp, exp_dp(k)); end
         if (bus.applied === 1'b1) seen++;
      end
      checks++; if (seen != 1) begin errors++; $display("FAIL load_applied_count got=%0d exp=1", seen); end
   endtask

   task automatic test_ignored_load();
      logic [15:0] shown;
      shown = 16'h0000;
      do_reset();
      wait_phase(2);
      drive_load(16'h4321, 4'b0000, 4'b1111);
      for (int i = 0; i < 3; i++) drive_load(16'h9999, 4'b1111, 4'b1111);
      for (int i = 0; i < 28; i++) begin
         step();
         checks++; if (bus.applied !== m_applied) begin errors++; $display("FAIL ign_applied k=%0d got=%b exp=%b", k, bus.applied, m_applied); end
         checks++; if (digit !== exp_digit(k)) begin errors++; $display("FAIL ign_digit k=%0d got=%h exp=%h", k, digit, exp_digit(k)); end
         if (k >= FR && (k % RD) == RD - 1) shown[((k / RD) % 4) * 4 +: 4] = digit;
      end
      checks++; if (shown !== 16'h4321) begin errors++; $display("FAIL ign_frame got=%h exp=4321", shown); end
   endtask

   task automatic test_boundary_load();
      int k0;
      int k_seen;
      k_seen = -1;
      wait_phase(FR - 1);
      drive_load(16'hABCD, 4'b1000, 4'b1111);
      k0 = k;
      checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL bnd_frame_start got=%b exp=1", frame_start); end
      checks++; if (bus.applied !== 1'b0) begin errors++; $display("FAIL bnd_applied_now got=%b exp=0", bus.applied); end
      for (int i = 0; i < FR + 4; i++) begin
         step();
         checks++; if (bus.applied !== m_applied) begin errors++; $display("FAIL bnd_applied k=%0d got=%b exp=%b", k, bus.applied, m_applied); end
         checks++; if (digit !== exp_digit(k) || dp !== exp_dp(k)) begin errors++; $display("FAIL bnd_digit k=%0d got=%h/%b exp=%h/%b", k, digit, dp, exp_digit(k), exp_dp(k)); end
         if (bus.applied === 1'b1 && k_seen < 0) k_seen = k;
      end
      checks++; if (k_seen - k0 != FR) begin errors++; $display("FAIL bnd_latency got=%0d exp=%0d", k_seen - k0, FR); end
   endtask

   task automatic test_mask();
      bit got;
      got = 1'b0;
      wait_phase(3);
      drive_load(16'h5A5A, 4'b0000, 4'b0101);
      for (int i = 0; i < FR + 2 && !got; i++) begin
         step();
         if (bus.applied === 1'b1) got = 1'b1;
      end
      checks++; if (!got) begin errors++; $display("FAIL mask_apply_timeout got=0 exp=1"); end
      for (int i = 0; i < FR; i++) begin
         step();
         checks++; if (AN !== exp_an(k, 4'b0101)) begin errors++; $display("FAIL mask_an k=%0d got=%b exp=%b", k, AN, exp_an(k, 4'b0101)); end
         if (S == 2'd1 || S == 2'd3) begin
            checks++; if (AN !== 4'b1111) begin errors++; $display("FAIL mask_dark k=%0d got=%b exp=1111", k, AN); end
         end
      end
   endtask

   task automatic test_reset_mid();
      wait_phase(6);
      drive_load(16'h7777, 4'b1111, 4'b1111);
      step();
      step();
      #2 reset = 1'b1;
      #1;
      checks++; if (AN !== 4'b1111) begin errors++; $display("FAIL mid_an got=%b exp=1111", AN); end
      checks++; if (S !== 2'd0) begin errors++; $display("FAIL mid_s got=%0d exp=0", S); end
      checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", bus.ready); end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_init();
      for (int i = 0; i < 40; i++) begin
         step();
         checks++; if (bus.applied !== 1'b0) begin errors++; $display("FAIL mid_applied k=%0d got=%b exp=0", k, bus.applied); end
         checks++; if (AN !== 4'b1111 || digit !== 4'h0) begin errors++; $display("FAIL mid_out k=%0d got=%b/%h exp=1111/0", k, AN, digit); end
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      reset       = 1'b1;
      bus.load    = 1'b0;
      bus.din     = 16'h0000;
      bus.dp_in   = 4'b0000;
      bus.mask_in = 4'b0000;
      model_init();
      test_reset();
      test_load_apply();
      test_ignored_load();
      test_boundary_load();
      test_mask();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
